pipe_stage_reg: RTL

Parametrised pipeline stage register: the next generation of the team's fixed-width IF/ID register. It carries a PC and an instruction word between pipeline stages with valid/ready handshaking on both sides and a one-entry skid slot, so full throughput is kept under downstream backpressure. The hazard unit can still freeze or flush the stage through a 2-bit control. It is instantiated at every stage boundary (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline stage register carrying a PC and an instruction word
// between two pipeline stages. Both sides use valid/ready handshaking, and a
// one-entry skid slot lets the stage keep accepting at full rate while the
// downstream side applies backpressure. The hazard unit can freeze or flush
// the stage through a 2-bit control. Used at every stage boundary.
//
// Optional feature macro: PIPE_STAGE_REG_PERF_EN
//   When defined, adds saturating stall/flush event counters (stall_cnt,
//   flush_cnt, CNT_W bits each). When undefined, those ports and counters
//   are absent and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned      PC_W     = 16,
   parameter int unsigned      IR_W     = 19,
   parameter logic [IR_W-1:0]  NOP_IR   = '0,
   parameter logic [PC_W-1:0]  PC_FLUSH = '0,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       ctrl,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [IR_W-1:0]  ir_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  pc_out,
   output logic [IR_W-1:0]  ir_out,
   output logic [1:0]       occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   logic            o_valid_q, o_valid_d;
   logic [PC_W-1:0] o_pc_q, o_pc_d;
   logic [IR_W-1:0] o_ir_q, o_ir_d;

   logic            s_valid_q, s_valid_d;
   logic [PC_W-1:0] s_pc_q, s_pc_d;
   logic [IR_W-1:0] s_ir_q, s_ir_d;

   logic flush;
   logic freeze;
   logic run;

   // Both encodings with bit 0 set mean flush, so bit 0 alone decides it.
   assign flush  = ctrl[0];
   assign freeze = (ctrl == 2'b10);
   assign run    = (ctrl == 2'b00);

   logic accept;
   logic consume;
   logic o_free;

   assign in_ready  = !reset && !s_valid_q && run;
   assign out_valid = o_valid_q && !freeze;

   assign accept  = in_valid && in_ready;
   // A flush discards O, so a transfer is only ever counted in normal mode.
   assign consume = out_valid && out_ready && run;
   assign o_free  = !o_valid_q || consume;

   assign pc_out    = o_pc_q;
   assign ir_out    = o_ir_q;
   assign occupancy = {1'b0, o_valid_q} + {1'b0, s_valid_q};

   always_comb begin
      o_valid_d = o_valid_q;
      o_pc_d    = o_pc_q;
      o_ir_d    = o_ir_q;
      s_valid_d = s_valid_q;
      s_pc_d    = s_pc_q;
      s_ir_d    = s_ir_q;

      if (flush) begin
         o_valid_d = 1'b0;
         o_pc_d    = PC_FLUSH;
         o_ir_d    = NOP_IR;
         s_valid_d = 1'b0;
      end else if (run) begin
         if (o_free) begin
            if (s_valid_q) begin
               // Drain the skid slot first to keep FIFO order.
               o_valid_d = 1'b1;
               o_pc_d    = s_pc_q;
               o_ir_d    = s_ir_q;
               s_valid_d = 1'b0;
            end else if (accept) begin
               o_valid_d = 1'b1;
               o_pc_d    = pc_in;
               o_ir_d    = ir_in;
            end else begin
               o_valid_d = 1'b0;
            end
         end else if (accept) begin
            s_valid_d = 1'b1;
            s_pc_d    = pc_in;
            s_ir_d    = ir_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid_q <= 1'b0;
         o_pc_q    <= PC_FLUSH;
         o_ir_q    <= NOP_IR;
         s_valid_q <= 1'b0;
         s_pc_q    <= PC_FLUSH;
         s_ir_q    <= NOP_IR;
      end else begin
         o_valid_q <= o_valid_d;
         o_pc_q    <= o_pc_d;
         o_ir_q    <= o_ir_d;
         s_valid_q <= s_valid_d;
         s_pc_q    <= s_pc_d;
         s_ir_q    <= s_ir_d;
      end
   end

`ifdef PIPE_STAGE_REG_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (freeze && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
